// File: rtl/tf_gen_ctrl.sv
// tf_gen_ctrl: sequences READ / WAIT / WRITE passes of the twiddle generator
// over every depth of every stage, then pulses done.
// Optional feature: define TF_CTRL_STALL_EN to add the stall input, which
// holds the FSM in READ (with TF_ren masked) while stall is high.
module tf_gen_ctrl #(
   parameter int unsigned IT_DEPTH      = 3,
   parameter int unsigned NUM_STAGE     = 4,
   parameter int unsigned BR_LAT        = 2,
   parameter int unsigned TF_CONST_BANK = 15,
   parameter int unsigned D_width       = $clog2(((IT_DEPTH > NUM_STAGE) ?
                                          ((IT_DEPTH > TF_CONST_BANK) ? IT_DEPTH : TF_CONST_BANK) :
                                          ((NUM_STAGE > TF_CONST_BANK) ? NUM_STAGE : TF_CONST_BANK)) + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
`ifdef TF_CTRL_STALL_EN
   input  logic               stall,
`endif
   output logic               TF_ren,
   output logic               TF_wen,
   output logic [D_width-1:0] it_depth_cnt,
   output logic [D_width-1:0] l,
   output logic [D_width-1:0] idx1,
   output logic [D_width-1:0] idx2,
   output logic [D_width-1:0] idx3,
   output logic [D_width-1:0] idx4,
   output logic [D_width-1:0] idx5,
   output logic [D_width-1:0] idx6,
   output logic [D_width-1:0] idx7,
   output logic [D_width-1:0] idx8,
   output logic [D_width-1:0] idx9,
   output logic [D_width-1:0] idx10,
   output logic [D_width-1:0] idx11,
   output logic [D_width-1:0] idx12,
   output logic [D_width-1:0] idx13,
   output logic [D_width-1:0] idx14,
   output logic [D_width-1:0] idx15,
   output logic               busy,
   output logic               done
);

   localparam int unsigned NUM_IDX = 15;
   localparam int unsigned WAIT_W  = (BR_LAT > 1) ? $clog2(BR_LAT) : 1;

   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [D_width-1:0]  depth_q, depth_d;
   logic [D_width-1:0]  l_q, l_d;
   logic [D_width-1:0]  idx_q [NUM_IDX];
   logic [D_width-1:0]  idx_d [NUM_IDX];
   logic                ren_q, ren_d;
   logic                wen_q, wen_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                rd_go;

`ifdef TF_CTRL_STALL_EN
   assign rd_go  = ~stall;
   assign TF_ren = ren_q & ~stall;
`else
   assign rd_go  = 1'b1;
   assign TF_ren = ren_q;
`endif

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         wait_q  <= '0;
         depth_q <= '0;
         l_q     <= '0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int unsigned k = 0; k < NUM_IDX; k++) idx_q[k] <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         depth_q <= depth_d;
         l_q     <= l_d;
         ren_q   <= ren_d;
         wen_q   <= wen_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         for (int unsigned k = 0; k < NUM_IDX; k++) idx_q[k] <= idx_d[k];
      end
   end

   // Next state, counter advance and next output values
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      depth_d = depth_q;
      l_d     = l_q;
      for (int unsigned k = 0; k < NUM_IDX; k++) idx_d[k] = idx_q[k];

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               depth_d = '0;
               l_d     = D_width'(1);
            end
         end
         READ: begin
            wait_d = '0;
            if (rd_go) state_d = WAIT;
         end
         WAIT: begin
            if (wait_q == WAIT_W'(BR_LAT - 1)) state_d = WRITE;
            else                               wait_d  = wait_q + WAIT_W'(1);
         end
         WRITE: begin
            if (depth_q < D_width'(IT_DEPTH)) begin
               depth_d = depth_q + D_width'(1);
               state_d = READ;
            end else if (l_q < D_width'(NUM_STAGE)) begin
               depth_d = '0;
               l_d     = l_q + D_width'(1);
               state_d = READ;
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Indices follow the stage; refreshed only when the stage changes
      if (l_d != l_q) begin
         for (int unsigned k = 0; k < NUM_IDX; k++)
            idx_d[k] = D_width'((32'(l_d) - 32'd1 + k) % TF_CONST_BANK);
      end

      ren_d  = (state_d == READ);
      wen_d  = (state_d == WRITE);
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign TF_wen       = wen_q;
   assign it_depth_cnt = depth_q;
   assign l            = l_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign idx1  = idx_q[0];
   assign idx2  = idx_q[1];
   assign idx3  = idx_q[2];
   assign idx4  = idx_q[3];
   assign idx5  = idx_q[4];
   assign idx6  = idx_q[5];
   assign idx7  = idx_q[6];
   assign idx8  = idx_q[7];
   assign idx9  = idx_q[8];
   assign idx10 = idx_q[9];
   assign idx11 = idx_q[10];
   assign idx12 = idx_q[11];
   assign idx13 = idx_q[12];
   assign idx14 = idx_q[13];
   assign idx15 = idx_q[14];

endmodule

// File: doc/tf_gen_ctrl.md
TF_GEN_CTRL -- requirements
Module: tf_gen_ctrl

Interface
REQ-001 SHALL have parameter IT_DEPTH, default 3: highest depth index sequenced; depths run 0..IT_DEPTH.
REQ-002 SHALL have parameter NUM_STAGE, default 4: number of stages; stage counter l runs 1..NUM_STAGE.
REQ-003 SHALL have parameter BR_LAT, default 2: Barrett multiplier latency in cycles.
REQ-004 SHALL have parameter TF_CONST_BANK, default 15: number of constant-table entries.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; the reset port keeps the codebase name rst.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle request to run a full schedule.
REQ-009 stall  input  1  hold request; present only with TF_CTRL_STALL_EN.
REQ-010 TF_ren  output  1  twiddle-generator read strobe.
REQ-011 TF_wen  output  1  twiddle-generator write strobe.
REQ-012 it_depth_cnt  output  D_width  depth index driven to the generator.
REQ-013 l  output  D_width  current stage number.
REQ-014 idx1..idx15  output  D_width each  constant-table indices.
REQ-015 busy  output  1  schedule in progress.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 FSM states SHALL be IDLE, READ, WAIT, WRITE and DONE.
REQ-018 IDLE SHALL go to READ on start=1, with l=1 and it_depth_cnt=0; start SHALL be ignored in every other state.
REQ-019 READ SHALL last one cycle: TF_ren=1, TF_wen=0. READ goes to WAIT.
REQ-020 WAIT SHALL last exactly BR_LAT cycles: TF_ren=0, TF_wen=0. WAIT goes to WRITE.
REQ-021 WRITE SHALL last one cycle: TF_ren=0, TF_wen=1.
  - it_depth_cnt held equal to the value driven during the matching READ.
  - Write therefore occurs BR_LAT+1 cycles after its READ.
REQ-022 After WRITE, depth and stage SHALL advance as follows:
  - it_depth_cnt<IT_DEPTH: it_depth_cnt+1, go to READ.
  - it_depth_cnt==IT_DEPTH and l<NUM_STAGE: it_depth_cnt=0, l+1, go to READ.
  - it_depth_cnt==IT_DEPTH and l==NUM_STAGE: go to DONE.
REQ-023 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-024 Each depth SHALL cost BR_LAT+2 cycles.
  - Full schedule, no stalls: NUM_STAGE*(IT_DEPTH+1)*(BR_LAT+2) cycles from the first READ through the last WRITE.
REQ-025 busy SHALL be 1 in READ, WAIT, WRITE and DONE, and 0 in IDLE.
REQ-026 idxk SHALL equal ((l-1)+(k-1)) mod TF_CONST_BANK for k=1..15.
  - Indices are registered, stable for a whole stage, and update in the same cycle l changes.
REQ-027 TF_ren and TF_wen SHALL never both be 1.
REQ-028 In IDLE, TF_ren=0 and TF_wen=0; it_depth_cnt and l keep their last values.
REQ-029 All counter wrap arithmetic SHALL be unsigned in D_width; no counter may exceed its bound.

Reset
REQ-030 While rst=0, the block SHALL be in IDLE with every output 0:
  - TF_ren, TF_wen, it_depth_cnt, l, idx1..idx15, busy, done.
REQ-031 Reset asserted mid-schedule SHALL abort immediately: outputs go to 0 asynchronously and no done is produced.
REQ-032 After reset deasserts, the first start SHALL begin a fresh schedule at l=1, depth 0.

Configuration
REQ-033 The optional feature SHALL be controlled by the macro TF_CTRL_STALL_EN.
REQ-034 With TF_CTRL_STALL_EN defined, the stall port exists and stall=1 freezes the FSM in READ:
  - TF_ren forced to 0; counters and indices held.
  - READ proceeds in the first cycle stall=0.
  - stall is ignored in WAIT, WRITE and DONE, so an in-flight multiply always completes.
REQ-035 Without TF_CTRL_STALL_EN, the stall port SHALL be absent and no hold behaviour exists.

Verification
REQ-036 Defaults, start pulse at cycle 0:
  - TF_ren at cycle 1, TF_wen at cycle 4, depth 1 read at cycle 5.
  - Last TF_wen at cycle 64, done at cycle 65, busy cycles 1..65.
REQ-037 Stage 1: idx1=0 and idx15=14. Stage 2: idx1=1 and idx15=0. Stage 4: idx1=3 and idx13=0.
REQ-038 A start pulse at cycle 20 of a running schedule SHALL leave the done cycle unchanged at 65.
REQ-039 rst=0 at cycle 30, then start after release: all outputs 0 during reset, no done, new schedule restarts at l=1, depth 0.
REQ-040 With TF_CTRL_STALL_EN, stall=1 for cycles 5..7:
  - TF_ren at cycle 8, depth 1 TF_wen at cycle 11, done at cycle 68.
REQ-041 Over every scenario, a checker SHALL confirm TF_ren&TF_wen is never 1 and done is never longer than one cycle.
